// File: rtl/axis_lane_packer.sv
// Packs KERNEL_SIZE narrow AXI-Stream lanes into one wide beat once every lane holds a word.
// Define AXIS_PACKER_TLAST_EN to add m_axis_tlast driven by a FRAME_BEATS-beat frame counter.
module axis_lane_packer #(
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned FRAME_BEATS = 16
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [KERNEL_SIZE-1:0]            s_axis_tvalid,
    input  logic [KERNEL_SIZE*DATA_WIDTH-1:0] s_axis_tdata,
    output logic [KERNEL_SIZE-1:0]            s_axis_tready,
    output logic                              m_axis_tvalid,
    output logic [KERNEL_SIZE*DATA_WIDTH-1:0] m_axis_tdata,
    input  logic                              m_axis_tready
`ifdef AXIS_PACKER_TLAST_EN
    ,
    output logic                              m_axis_tlast
`endif
);

    localparam int unsigned W = KERNEL_SIZE * DATA_WIDTH;

    if (FRAME_BEATS < 1) begin : g_frame_beats_check
        $error("FRAME_BEATS must be >= 1");
    end

    logic [KERNEL_SIZE-1:0] lane_full_q, lane_full_d;
    logic [W-1:0]           lane_data_q, lane_data_d;
    logic                   out_valid_q, out_valid_d;
    logic [W-1:0]           out_data_q, out_data_d;

    logic                   all_full;
    logic                   out_free;
    logic                   pack;
    logic                   out_hs;
    logic [KERNEL_SIZE-1:0] lane_accept;

    assign all_full      = &lane_full_q;
    assign out_free      = ~out_valid_q | m_axis_tready;
    assign pack          = all_full & out_free;
    assign out_hs        = out_valid_q & m_axis_tready;
    assign s_axis_tready = ~lane_full_q | {KERNEL_SIZE{pack}};
    assign lane_accept   = s_axis_tvalid & s_axis_tready;

    // A lane emptied by pack may refill in the same cycle, so accept wins over the clear.
    always_comb begin
        lane_full_d = lane_full_q & ~{KERNEL_SIZE{pack}};
        lane_data_d = lane_data_q;
        for (int unsigned i = 0; i < KERNEL_SIZE; i++) begin
            if (lane_accept[i]) begin
                lane_full_d[i] = 1'b1;
                lane_data_d[i*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q & ~m_axis_tready;
        out_data_d  = out_data_q;
        if (pack) begin
            out_valid_d = 1'b1;
            out_data_d  = lane_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            lane_full_q <= '0;
            lane_data_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            lane_full_q <= lane_full_d;
            lane_data_q <= lane_data_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_data_q;

`ifdef AXIS_PACKER_TLAST_EN
    localparam int unsigned          CNT_W    = $clog2(FRAME_BEATS) + 1;
    localparam logic [CNT_W-1:0]     LAST_IDX = CNT_W'(FRAME_BEATS - 1);

    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] pack_idx;
    logic             tlast_q, tlast_d;

    // The counter indexes the beat currently offered; a beat packed while another is
    // leaving takes the following index.
    always_comb begin
        cnt_next   = (beat_cnt_q == LAST_IDX) ? '0 : beat_cnt_q + 1'b1;
        beat_cnt_d = out_hs ? cnt_next : beat_cnt_q;
        pack_idx   = out_valid_q ? cnt_next : beat_cnt_q;
        tlast_d    = pack ? (pack_idx == LAST_IDX) : tlast_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            beat_cnt_q <= '0;
            tlast_q    <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            tlast_q    <= tlast_d;
        end
    end

    assign m_axis_tlast = tlast_q;
`endif

endmodule

// File: tb/tb_axis_lane_packer.sv
// Directed bench for axis_lane_packer: vector table for aligned/skewed traffic plus
// hand-written backpressure, mid-collect reset and frame-boundary sequences.
module tb_axis_lane_packer;

    localparam int unsigned K  = 3;
    localparam int unsigned DW = 8;
    localparam int unsigned FB = 4;

    logic              clk;
    logic              rstn;
    logic [K-1:0]      s_tvalid;
    logic [K*DW-1:0]   s_tdata;
    logic [K-1:0]      s_tready;
    logic              m_tvalid;
    logic [K*DW-1:0]   m_tdata;
    logic              m_tready;
`ifdef AXIS_PACKER_TLAST_EN
    logic              m_tlast;
`endif

    int checks   = 0;
    int failures = 0;

    axis_lane_packer #(
        .KERNEL_SIZE (K),
        .DATA_WIDTH  (DW),
        .FRAME_BEATS (FB)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tdata  (s_tdata),
        .s_axis_tready (s_tready),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tdata  (m_tdata),
        .m_axis_tready (m_tready)
`ifdef AXIS_PACKER_TLAST_EN
        ,
        .m_axis_tlast  (m_tlast)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic          rst;
        logic [K-1:0]  vld;
        logic [K*DW-1:0] data;
        logic          mrdy;
        logic [K-1:0]  exp_srdy;
        logic          exp_mvld;
        logic [K*DW-1:0] exp_mdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic [K-1:0] vld, logic [K*DW-1:0] data,
                                logic mrdy, logic [K-1:0] esr, logic emv,
                                logic [K*DW-1:0] emd);
        vec_t v;
        v.rst = rst; v.vld = vld; v.data = data; v.mrdy = mrdy;
        v.exp_srdy = esr; v.exp_mvld = emv; v.exp_mdata = emd;
        return v;
    endfunction

    // Aligned stream word n: lane i carries 16*i+n.
    function automatic logic [K*DW-1:0] beat(int n);
        logic [7:0] b;
        b = 8'(n);
        return {8'h20 + b, 8'h10 + b, b};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic [K-1:0] v, logic [K*DW-1:0] d, logic r);
        @(negedge clk);
        s_tvalid = v;
        s_tdata  = d;
        m_tready = r;
        #3;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rstn = 1'b0; s_tvalid = '0; s_tdata = '0; m_tready = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        int j;
        int n;
        int cyc;
        rstn = 1'b0; s_tvalid = '0; s_tdata = '0; m_tready = 1'b1;

        // Aligned streaming: ten beats, first valid after the 2-cycle fill.
        vecs.push_back(mk(1'b1, 3'b000, '0, 1'b1, 3'b111, 1'b0, '0));
        for (int i = 0; i < 13; i++)
            vecs.push_back(mk(1'b0, (i < 10) ? 3'b111 : 3'b000, beat(i), 1'b1, 3'b111,
                              (i >= 2 && i <= 11), (i >= 2) ? beat(i - 2) : '0));

        // Skewed arrival; lane0 keeps offering 0xB0 while stalled, accepted on the pack cycle.
        vecs.push_back(mk(1'b1, 3'b000, '0,         1'b1, 3'b111, 1'b0, '0));
        vecs.push_back(mk(1'b0, 3'b001, 24'h0000A0, 1'b1, 3'b111, 1'b0, '0));
        vecs.push_back(mk(1'b0, 3'b001, 24'h0000B0, 1'b1, 3'b110, 1'b0, '0));
        vecs.push_back(mk(1'b0, 3'b001, 24'h0000B0, 1'b1, 3'b110, 1'b0, '0));
        vecs.push_back(mk(1'b0, 3'b011, 24'h00A1B0, 1'b1, 3'b110, 1'b0, '0));
        vecs.push_back(mk(1'b0, 3'b001, 24'h0000B0, 1'b1, 3'b100, 1'b0, '0));
        vecs.push_back(mk(1'b0, 3'b001, 24'h0000B0, 1'b1, 3'b100, 1'b0, '0));
        vecs.push_back(mk(1'b0, 3'b001, 24'h0000B0, 1'b1, 3'b100, 1'b0, '0));
        vecs.push_back(mk(1'b0, 3'b101, 24'hA200B0, 1'b1, 3'b100, 1'b0, '0));
        vecs.push_back(mk(1'b0, 3'b001, 24'h0000B0, 1'b1, 3'b111, 1'b0, '0));
        vecs.push_back(mk(1'b0, 3'b000, 24'h000000, 1'b1, 3'b110, 1'b1, 24'hA2A1A0));
        vecs.push_back(mk(1'b0, 3'b000, 24'h000000, 1'b1, 3'b110, 1'b0, '0));

        foreach (vecs[i]) begin
            @(negedge clk);
            rstn     = ~vecs[i].rst;
            s_tvalid = vecs[i].vld;
            s_tdata  = vecs[i].data;
            m_tready = vecs[i].mrdy;
            #3;
            if (!vecs[i].rst) begin
                check($sformatf("vec%0d_srdy", i), 32'(s_tready), 32'(vecs[i].exp_srdy));
                check($sformatf("vec%0d_mvld", i), 32'(m_tvalid), 32'(vecs[i].exp_mvld));
                if (vecs[i].exp_mvld)
                    check($sformatf("vec%0d_mdata", i), 32'(m_tdata), 32'(vecs[i].exp_mdata));
            end
        end

        // Backpressure: downstream stalls cycles 4-8 while all lanes keep streaming.
        reset_dut();
        j = 0; n = 0; cyc = 0;
        while (j < 12 && cyc < 60) begin
            drive((n < 12) ? 3'b111 : 3'b000, beat(n), !(cyc >= 4 && cyc <= 8));
            if (m_tvalid) begin
                check("bp_data", 32'(m_tdata), 32'(beat(j)));
                if (m_tready) j++;
            end
            if (cyc >= 4 && cyc <= 8) begin
                check("bp_stall_srdy", 32'(s_tready), 32'(0));
                check("bp_stall_mvld", 32'(m_tvalid), 32'(1));
            end
            if (s_tvalid == 3'b111 && s_tready == 3'b111) n++;
            cyc++;
        end
        check("bp_beat_count", 32'(j), 32'(12));

        // Reset mid-collect: partial lanes and the last output data are discarded.
        drive(3'b011, 24'h006655, 1'b1);
        check("rmc_idle_srdy", 32'(s_tready), 32'(3'b111));
        check("rmc_idle_mvld", 32'(m_tvalid), 32'(0));
        drive(3'b000, '0, 1'b1);
        check("rmc_partial_srdy", 32'(s_tready), 32'(3'b100));
        @(negedge clk);
        rstn = 1'b0;
        #3;
        check("rmc_in_reset_mvld", 32'(m_tvalid), 32'(0));
        @(negedge clk);
        rstn = 1'b1;
        #3;
        check("rmc_post_srdy", 32'(s_tready), 32'(3'b111));
        check("rmc_post_mvld", 32'(m_tvalid), 32'(0));
        check("rmc_post_mdata", 32'(m_tdata), 32'(0));
        drive(3'b111, 24'h332211, 1'b1);
        check("rmc_load_mvld", 32'(m_tvalid), 32'(0));
        drive(3'b000, '0, 1'b1);
        check("rmc_pack_mvld", 32'(m_tvalid), 32'(0));
        check("rmc_pack_srdy", 32'(s_tready), 32'(3'b111));
        drive(3'b000, '0, 1'b1);
        check("rmc_beat_mvld", 32'(m_tvalid), 32'(1));
        check("rmc_beat_mdata", 32'(m_tdata), 32'(24'h332211));

        // Frame boundaries: nine aligned beats, tlast on the last beat of each FB-beat frame.
        reset_dut();
        j = 0; n = 0; cyc = 0;
        while (j < 9 && cyc < 40) begin
            drive((n < 9) ? 3'b111 : 3'b000, beat(n), 1'b1);
            if (m_tvalid) begin
                check($sformatf("frm_data%0d", j), 32'(m_tdata), 32'(beat(j)));
`ifdef AXIS_PACKER_TLAST_EN
                check($sformatf("frm_tlast%0d", j), 32'(m_tlast), 32'((j % FB) == (FB - 1)));
`endif
                j++;
            end
            if (s_tvalid == 3'b111 && s_tready == 3'b111) n++;
            cyc++;
        end
        check("frm_beat_count", 32'(j), 32'(9));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_lane_packer.md
# axis_lane_packer

Gathers KERNEL_SIZE independent narrow AXI-Stream lanes into one wide AXI-Stream beat.
- Each lane has its own valid/ready and a one-entry holding register; a wide beat is emitted only when every lane holds a word.
- Sits downstream of the per-lane kernel datapaths and re-merges their results into a single packed stream.
- Inverse of the lane unpacker, with an identical lane-to-bit mapping.

## Interface
- KERNEL_SIZE, 3, number of input lanes
- DATA_WIDTH, 8, width of each lane word
- FRAME_BEATS, 16, output beats per frame; used only with AXIS_PACKER_TLAST_EN; must be >= 1
- clk  input  1  single clock; all logic on rising edge
- rstn  input  1  reset, synchronous, active-low
- s_axis_tvalid  input  KERNEL_SIZE  per-lane valid
- s_axis_tdata  input  KERNEL_SIZE*DATA_WIDTH  lane i at bits [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
- s_axis_tready  output  KERNEL_SIZE  per-lane ready
- m_axis_tvalid  output  1  packed beat valid
- m_axis_tdata  output  KERNEL_SIZE*DATA_WIDTH  packed beat; lane i in the same bit slice as the input
- m_axis_tready  input  1  downstream ready
- m_axis_tlast  output  1  frame end; present only with AXIS_PACKER_TLAST_EN

## Operation
- Per-lane state: lane_full[i] and lane_data[i].
- Output state: out_valid (drives m_axis_tvalid) and out_data (drives m_axis_tdata).
- Transfer conditions:
  - all_full = &lane_full.
  - out_free = ~out_valid | m_axis_tready.
  - pack = all_full & out_free.
- s_axis_tready[i] = ~lane_full[i] | pack. This is combinational from m_axis_tready and is the only such path.
- Lane accept (s_axis_tvalid[i] & s_axis_tready[i]): lane_data[i] <= input slice, lane_full[i] <= 1.
- On pack:
  - out_data <= concatenation of lane_data; out_valid <= 1.
  - Every lane_full clears, unless that lane accepts in the same cycle, in which case it stays 1 with the new data.
- Output handshake (m_axis_tvalid & m_axis_tready) without pack: out_valid <= 0.
- Output handshake with pack: out_valid stays 1 and out_data takes the new beat.
- Skewed arrival: early lanes hold their word with s_axis_tready low until the slowest lane delivers and pack fires. No lane word is ever dropped, duplicated, or reordered relative to its own lane.
- Implicit state machine per beat: COLLECTING (some lane empty) -> READY (all_full, output blocked) -> PACKED (pack). The bench checks it through lane_full and out_valid.

## Timing
- Reset (rstn low at a rising edge) forces:
  - lane_full = 0, out_valid = 0, out_data = 0, lane_data = 0.
  - s_axis_tready = all ones one cycle after reset, because ready reflects lane_full = 0.
  - m_axis_tlast = 0 and beat counter = 0.
- Reset mid-operation discards partially collected lanes and any pending output beat. The first post-reset beat is built only from words accepted after reset.
- Latency: the last lane is accepted at edge k, and m_axis_tvalid rises after edge k+1.
- Throughput: one packed beat per cycle when all lanes are valid every cycle and m_axis_tready is held high.
- Backpressure: while m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tlast stay stable. Lanes may still fill, then stall.
- FRAME_BEATS=1 with tlast: every beat has m_axis_tlast=1.

## Configuration
- Macro AXIS_PACKER_TLAST_EN.
- Defined:
  - A beat counter of width $clog2(FRAME_BEATS)+1 counts output handshakes and wraps from FRAME_BEATS-1 to 0.
  - m_axis_tlast is registered with out_data on pack, set to 1 when the beat being packed is at index FRAME_BEATS-1 of the frame.
  - The counter is reset by rstn only.
- Undefined: m_axis_tlast, the counter, and FRAME_BEATS usage are absent, and the port list ends at m_axis_tready.

## Test plan
- Aligned streaming, K=3, DW=8: all lanes valid each cycle with lane i sending 16*i+n for n=0..9, m_axis_tready=1 -> ten beats, beat n = {8'h2n,8'h1n,8'h0n}, one beat per cycle after the 2-cycle fill.
- Skewed arrival: lane0 valid cycle 0, lane1 cycle 3, lane2 cycle 7, data 0xA0/0xA1/0xA2 -> s_axis_tready[0] low cycles 1-7, m_axis_tvalid high after cycle 8 edge with tdata 0xA2A1A0.
- Backpressure: m_axis_tready=0 for 5 cycles with all lanes streaming -> tdata/tvalid stable, every s_axis_tready low once lanes fill. Release -> beats continue in order with no loss or duplication.
- Reset mid-collect: lanes 0 and 1 loaded, rstn=0 for one cycle, then all three lanes send 0x11/0x22/0x33 -> m_axis_tvalid=0 through reset, first beat 0x332211.
- tlast (macro defined, FRAME_BEATS=4): 9 beats streamed -> m_axis_tlast=1 on beats 3 and 7 only, 0 on beat 8. Repeat with macro undefined -> beat data identical.
